// File: rtl/fmul_pkg.sv
// Shared definitions for the fractional-multiply arbiter: operand modes,
// FSM states, requester-count bounds and a small index-wrap helper.
package fmul_pkg;

   localparam int N_REQ_MIN = 2;
   localparam int N_REQ_MAX = 4;

   typedef enum logic [1:0] {
      MODE_FMUL     = 2'b00,
      MODE_FMULS    = 2'b01,
      MODE_FMULSU   = 2'b10,
      MODE_FMUL_ALT = 2'b11
   } fmul_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_RESP = 2'd2
   } fmul_state_e;

   // Reduces a small sum (always below 2*n) modulo n.
   function automatic logic [1:0] wrap_idx(input logic [2:0] v, input int n);
      return 2'((int'(v) >= n) ? int'(v) - n : int'(v));
   endfunction

endpackage

// File: rtl/fmul_arbiter_if.sv
// Request/response bundle between the requesters, the consumer and the
// fractional-multiply arbiter; the arbiter uses the slave modport.
interface fmul_arbiter_if
   import fmul_pkg::*;
#(
   parameter int N_REQ = 2
);
   logic [N_REQ-1:0]   i_req_valid;
   logic [N_REQ-1:0]   o_req_ready;
   logic [8*N_REQ-1:0] i_rd;
   logic [8*N_REQ-1:0] i_rr;
   logic [2*N_REQ-1:0] i_mode;
   logic               o_rsp_valid;
   logic               i_rsp_ready;
   logic [1:0]         o_rsp_id;
   logic [7:0]         o_r1;
   logic [7:0]         o_r0;
   logic               o_c;
   logic               o_z;

   modport master (
      output i_req_valid, i_rd, i_rr, i_mode, i_rsp_ready,
      input  o_req_ready, o_rsp_valid, o_rsp_id, o_r1, o_r0, o_c, o_z
   );

   modport slave (
      input  i_req_valid, i_rd, i_rr, i_mode, i_rsp_ready,
      output o_req_ready, o_rsp_valid, o_rsp_id, o_r1, o_r0, o_c, o_z
   );
endinterface

// File: rtl/fmul_core.sv
// Combinational 8x8 fractional multiply: the product is shifted left by one,
// carry takes the bit shifted out and zero looks at the shifted result.
module fmul_core
   import fmul_pkg::*;
(
   input  logic [7:0] rd,
   input  logic [7:0] rr,
   input  fmul_mode_e mode,
   output logic [7:0] r1,
   output logic [7:0] r0,
   output logic       c,
   output logic       z
);

   logic        rd_signed;
   logic        rr_signed;
   logic [15:0] a;
   logic [15:0] b;
   logic [15:0] p;

   // Sign-extend to 16 bits so the low half of an unsigned multiply is exact.
   always_comb begin
      rd_signed = (mode == MODE_FMULS) || (mode == MODE_FMULSU);
      rr_signed = (mode == MODE_FMULS);
      a         = {{8{rd_signed & rd[7]}}, rd};
      b         = {{8{rr_signed & rr[7]}}, rr};
      p         = a * b;
      r1        = p[14:7];
      r0        = {p[6:0], 1'b0};
      c         = p[15];
      z         = (p[14:0] == 15'd0);
   end

endmodule

// File: rtl/fmul_arbiter.sv
// Arbitrates N_REQ requesters onto one fractional multiplier (IDLE/CALC/RESP).
// Define FMUL_ARB_RR_EN for round-robin grant; otherwise lowest index wins.
module fmul_arbiter
   import fmul_pkg::*;
#(
   parameter int N_REQ = 2
) (
   input logic           i_clk,
   input logic           i_rst_n,
   fmul_arbiter_if.slave bus
);

   fmul_state_e state_q;
   fmul_state_e state_d;
   logic        grant_any;
   logic [1:0]  grant_idx;
   logic        accept;
   logic [7:0]  sel_rd;
   logic [7:0]  sel_rr;
   fmul_mode_e  sel_mode;
   logic [7:0]  rd_q;
   logic [7:0]  rr_q;
   fmul_mode_e  mode_q;
   logic [1:0]  id_q;
   logic [7:0]  r1_q;
   logic [7:0]  r0_q;
   logic        c_q;
   logic        z_q;
   logic [7:0]  core_r1;
   logic [7:0]  core_r0;
   logic        core_c;
   logic        core_z;

`ifdef FMUL_ARB_RR_EN
   logic [1:0]  rr_ptr;

   // The pointer holds the first index to search, so it moves past each winner.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rr_ptr <= '0;
      end else if (accept) begin
         rr_ptr <= wrap_idx({1'b0, grant_idx} + 3'd1, N_REQ);
      end
   end
`endif

   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
`ifdef FMUL_ARB_RR_EN
      for (int i = 0; i < N_REQ; i++) begin
         for (int j = 0; j < N_REQ; j++) begin
            if (!grant_any && bus.i_req_valid[j] &&
                (wrap_idx({1'b0, rr_ptr} + 3'(i), N_REQ) == 2'(j))) begin
               grant_any = 1'b1;
               grant_idx = 2'(j);
            end
         end
      end
`else
      for (int i = 0; i < N_REQ; i++) begin
         if (!grant_any && bus.i_req_valid[i]) begin
            grant_any = 1'b1;
            grant_idx = 2'(i);
         end
      end
`endif
   end

   always_comb begin
      sel_rd   = '0;
      sel_rr   = '0;
      sel_mode = MODE_FMUL;
      for (int j = 0; j < N_REQ; j++) begin
         if (grant_idx == 2'(j)) begin
            sel_rd   = bus.i_rd[8*j +: 8];
            sel_rr   = bus.i_rr[8*j +: 8];
            sel_mode = fmul_mode_e'(bus.i_mode[2*j +: 2]);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (grant_any) begin
               accept  = 1'b1;
               state_d = ST_CALC;
            end
         end
         ST_CALC: state_d = ST_RESP;
         ST_RESP: begin
            if (bus.i_rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Ready depends only on state and request valids, never on the consumer.
   always_comb begin
      bus.o_req_ready = '0;
      for (int j = 0; j < N_REQ; j++) begin
         bus.o_req_ready[j] = i_rst_n && (state_q == ST_IDLE) && grant_any &&
                              (grant_idx == 2'(j));
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Operands are captured at accept so requesters may move on immediately.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_q   <= '0;
         rr_q   <= '0;
         mode_q <= MODE_FMUL;
         id_q   <= '0;
         r1_q   <= '0;
         r0_q   <= '0;
         c_q    <= 1'b0;
         z_q    <= 1'b0;
      end else begin
         if (accept) begin
            rd_q   <= sel_rd;
            rr_q   <= sel_rr;
            mode_q <= sel_mode;
            id_q   <= grant_idx;
         end
         if (state_q == ST_CALC) begin
            r1_q <= core_r1;
            r0_q <= core_r0;
            c_q  <= core_c;
            z_q  <= core_z;
         end
      end
   end

   fmul_core u_core (
      .rd   (rd_q),
      .rr   (rr_q),
      .mode (mode_q),
      .r1   (core_r1),
      .r0   (core_r0),
      .c    (core_c),
      .z    (core_z)
   );

   assign bus.o_rsp_valid = (state_q == ST_RESP);
   assign bus.o_rsp_id    = id_q;
   assign bus.o_r1        = r1_q;
   assign bus.o_r0        = r0_q;
   assign bus.o_c         = c_q;
   assign bus.o_z         = z_q;

endmodule

// File: tb/tb_fmul_arbiter.sv
// Self-checking bench for fmul_arbiter: directed and random operations checked
// against an arithmetic reference model; follows FMUL_ARB_RR_EN if defined.
module tb_fmul_arbiter;

   localparam int N  = 2;
   localparam int DW = 8 * N;
   localparam int MW = 2 * N;

   logic clk;
   logic rst_n;
   int   assertCount;
   int   failCount;
   int   rrPtr;

   fmul_arbiter_if #(.N_REQ(N)) bus ();

   fmul_arbiter #(.N_REQ(N)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed no $finish, expected end of test");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Winner according to the arbitration rule, -1 if nobody is asking.
   function automatic int pickWinner(input logic [N-1:0] valid);
`ifdef FMUL_ARB_RR_EN
      for (int i = 0; i < N; i++) begin
         int k;
         k = (rrPtr + i) % N;
         if (valid[k]) return k;
      end
`else
      for (int i = 0; i < N; i++) begin
         if (valid[i]) return i;
      end
`endif
      return -1;
   endfunction

   // Returns {c, z, r1, r0}: the product doubled as a 1.15 fraction.
   function automatic logic [17:0] refResult(input logic [7:0] rd, input logic [7:0] rr,
                                             input logic [1:0] mode);
      int          a;
      int          b;
      int          p;
      logic [31:0] pbits;
      logic [15:0] frac;
      a     = (mode == 2'b01 || mode == 2'b10) ? int'($signed(rd)) : int'(rd);
      b     = (mode == 2'b01) ? int'($signed(rr)) : int'(rr);
      p     = a * b;
      pbits = p;
      frac  = 16'(p * 2);
      return {pbits[15], (frac == 16'd0), frac};
   endfunction

   task automatic checkResponse(input string tag, input int win, input logic [17:0] exp);
      checkOutput({tag, "_rsp_valid"}, 32'(bus.o_rsp_valid), 32'd1);
      checkOutput({tag, "_rsp_id"},    32'(bus.o_rsp_id),    32'(win));
      checkOutput({tag, "_r1"},        32'(bus.o_r1),        32'(exp[15:8]));
      checkOutput({tag, "_r0"},        32'(bus.o_r0),        32'(exp[7:0]));
      checkOutput({tag, "_c"},         32'(bus.o_c),         32'(exp[17]));
      checkOutput({tag, "_z"},         32'(bus.o_z),         32'(exp[16]));
   endtask

   // Entered just after a rising edge with the DUT idle; leaves it idle again.
   task automatic applyStimulus(input logic [N-1:0] valid, input logic [DW-1:0] rdv,
                                input logic [DW-1:0] rrv, input logic [MW-1:0] modev,
                                input int stall);
      int          win;
      logic [17:0] exp;
      logic [N-1:0] expReady;
      bus.i_req_valid = valid;
      bus.i_rd        = rdv;
      bus.i_rr        = rrv;
      bus.i_mode      = modev;
      bus.i_rsp_ready = (stall == 0);
      win      = pickWinner(valid);
      expReady = '0;
      exp      = '0;
      if (win >= 0) begin
         expReady[win] = 1'b1;
         exp = refResult(rdv[8*win +: 8], rrv[8*win +: 8], modev[2*win +: 2]);
      end
      @(negedge clk);
      checkOutput("idle_req_ready", 32'(bus.o_req_ready), 32'(expReady));
      @(posedge clk); #1;
`ifdef FMUL_ARB_RR_EN
      rrPtr = (win + 1) % N;
`endif
      bus.i_rd   = DW'($urandom);
      bus.i_rr   = DW'($urandom);
      bus.i_mode = MW'($urandom);
      @(negedge clk);
      checkOutput("calc_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
      checkOutput("calc_req_ready", 32'(bus.o_req_ready), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      checkResponse("resp", win, exp);
      for (int s = 1; s <= stall; s++) begin
         @(posedge clk); #1;
         if (s == stall) bus.i_rsp_ready = 1'b1;
         @(negedge clk);
         checkResponse("hold", win, exp);
         checkOutput("hold_req_ready", 32'(bus.o_req_ready), 32'd0);
      end
      @(posedge clk); #1;
      checkOutput("done_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
   endtask

   initial begin
      logic [N-1:0] rv;
      assertCount     = 0;
      failCount       = 0;
      rrPtr           = 0;
      rst_n           = 1'b0;
      bus.i_req_valid = '1;
      bus.i_rd        = '0;
      bus.i_rr        = '0;
      bus.i_mode      = '0;
      bus.i_rsp_ready = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_req_ready", 32'(bus.o_req_ready), 32'd0);
      checkOutput("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
      checkOutput("rst_rsp_id",    32'(bus.o_rsp_id),    32'd0);
      checkOutput("rst_r1",        32'(bus.o_r1),        32'd0);
      checkOutput("rst_r0",        32'(bus.o_r0),        32'd0);
      checkOutput("rst_c",         32'(bus.o_c),         32'd0);
      checkOutput("rst_z",         32'(bus.o_z),         32'd0);
      @(posedge clk); #1;
      rst_n           = 1'b1;
      bus.i_req_valid = '0;
      @(negedge clk);
      checkOutput("idle_no_req_ready", 32'(bus.o_req_ready), 32'd0);
      @(posedge clk); #1;

      $display("[TB] directed operations");
      applyStimulus(2'b01, {8'h00, 8'h80}, {8'h00, 8'hFF}, {2'b00, 2'b10}, 0);
      applyStimulus(2'b10, {8'h80, 8'h11}, {8'h80, 8'h22}, {2'b00, 2'b01}, 0);
      applyStimulus(2'b01, {8'h7F, 8'h80}, {8'h7F, 8'h80}, {2'b10, 2'b01}, 0);
      applyStimulus(2'b10, {8'h00, 8'hAA}, {8'h5A, 8'hAA}, {2'b00, 2'b00}, 0);
      applyStimulus(2'b01, {8'h00, 8'hFF}, {8'h00, 8'hFF}, {2'b00, 2'b11}, 0);
      applyStimulus(2'b10, {8'hC3, 8'h00}, {8'h9D, 8'h00}, {2'b10, 2'b00}, 1);

      $display("[TB] contention");
      repeat (4) applyStimulus(2'b11, {8'hC5, 8'h33}, {8'h71, 8'hE9}, {2'b01, 2'b10}, 0);

      $display("[TB] backpressure");
      applyStimulus(2'b11, {8'h9C, 8'h47}, {8'hB2, 8'hF0}, {2'b10, 2'b01}, 5);

      $display("[TB] reset during CALC");
      bus.i_req_valid = 2'b01;
      bus.i_rd        = {8'h55, 8'h7E};
      bus.i_rr        = {8'h66, 8'h93};
      bus.i_mode      = {2'b00, 2'b01};
      bus.i_rsp_ready = 1'b1;
      @(posedge clk); #1;
      rst_n           = 1'b0;
      bus.i_req_valid = 2'b11;
      rrPtr           = 0;
      @(negedge clk);
      checkOutput("calc_rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
      checkOutput("calc_rst_req_ready", 32'(bus.o_req_ready), 32'd0);
      checkOutput("calc_rst_rsp_id",    32'(bus.o_rsp_id),    32'd0);
      checkOutput("calc_rst_r1",        32'(bus.o_r1),        32'd0);
      checkOutput("calc_rst_r0",        32'(bus.o_r0),        32'd0);
      checkOutput("calc_rst_c",         32'(bus.o_c),         32'd0);
      checkOutput("calc_rst_z",         32'(bus.o_z),         32'd0);
      @(posedge clk); #1;
      rst_n           = 1'b1;
      bus.i_req_valid = '0;
      repeat (3) begin
         @(negedge clk);
         checkOutput("post_rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
      end
      @(posedge clk); #1;
      applyStimulus(2'b11, {8'h21, 8'h84}, {8'h43, 8'hFE}, {2'b00, 2'b10}, 0);

      $display("[TB] random operations");
      for (int t = 0; t < 24; t++) begin
         rv = N'($urandom_range(1, (1 << N) - 1));
         applyStimulus(rv, DW'($urandom), DW'($urandom), MW'($urandom),
                       int'($urandom_range(0, 2)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/fmul_arbiter.md
FMUL_ARBITER -- requirements
Module: fmul_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 2, number of requesters, legal range 2..4.
REQ-002 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_req_valid  input  N_REQ  per-requester request valid.
REQ-005 SHALL have port o_req_ready  output  N_REQ  per-requester accept; at most one bit high.
REQ-006 SHALL have port i_rd  input  8*N_REQ  multiplicand; slice k belongs to requester k.
REQ-007 SHALL have port i_rr  input  8*N_REQ  multiplier; slice k belongs to requester k.
REQ-008 SHALL have port i_mode  input  2*N_REQ  op per requester: 00 FMUL (u*u), 01 FMULS (s*s), 10 FMULSU (s*u), 11 treated as 00.
REQ-009 SHALL have port o_rsp_valid  output  1  result valid.
REQ-010 SHALL have port i_rsp_ready  input  1  consumer accepts result.
REQ-011 SHALL have port o_rsp_id  output  2  index of requester owning the result.
REQ-012 SHALL have port o_r1  output  8  result high byte.
REQ-013 SHALL have port o_r0  output  8  result low byte.
REQ-014 SHALL have port o_c  output  1  carry flag.
REQ-015 SHALL have port o_z  output  1  zero flag.

Function
REQ-016 SHALL implement FSM states IDLE, CALC, RESP; IDLE->CALC on accept, CALC->RESP unconditionally, RESP->IDLE when i_rsp_ready high.
REQ-017 SHALL assert o_req_ready[k] only in IDLE, combinationally, for the single granted requester with i_req_valid[k] high; accept = valid & ready on a rising edge.
REQ-018 SHALL latch rd, rr, mode, and id of the accepted requester on accept; later changes to requester inputs have no effect.
REQ-019 SHALL in CALC compute 16-bit product P with operand signedness per mode, and register o_r1 = P[14:7], o_r0 = {P[6:0],0}, o_c = P[15], o_z = ({o_r1,o_r0} == 0).
REQ-020 SHALL assert o_rsp_valid only in RESP; accept-to-o_rsp_valid latency is exactly 2 cycles.
REQ-021 SHALL hold o_rsp_valid, o_rsp_id, o_r1, o_r0, o_c, o_z stable while o_rsp_valid is high and i_rsp_ready is low.
REQ-022 SHALL accept no new request in CALC or RESP; a response accepted in RESP allows a new accept on the next IDLE cycle (minimum 3 cycles per operation).
REQ-023 SHALL have no combinational path from i_rsp_ready to o_req_ready.
REQ-024 SHALL, for mode 11, produce the same result as mode 00.

Reset
REQ-025 SHALL, while i_rst_n is low, force state IDLE, o_req_ready = 0, o_rsp_valid = 0, o_rsp_id = 0, o_r1 = 0, o_r0 = 0, o_c = 0, o_z = 0, and round-robin pointer = 0.
REQ-026 SHALL, on reset asserted in CALC or RESP, discard the in-flight operation with no response.

Configuration
REQ-027 SHALL, with FMUL_ARB_RR_EN defined, grant round-robin: search starts at requester (last granted + 1) mod N_REQ; pointer updates only on accept.
REQ-028 SHALL, without FMUL_ARB_RR_EN, grant fixed priority with the lowest valid index winning and no pointer register.

Structure
REQ-029 SHALL place the mode encoding, FSM state enum, and N_REQ bounds in shared package fmul_pkg.
REQ-030 SHALL instantiate one combinational sub-module fmul_core (rd, rr, mode -> r1, r0, c, z) used in CALC.

Verification
REQ-031 SHALL cover FMULSU: rd=0x80, rr=0xFF -> r1=0x01, r0=0x00, c=1, z=0, 2 cycles after accept.
REQ-032 SHALL cover FMUL and FMULS: rd=0x80, rr=0x80 -> r1=0x80, r0=0x00, c=0 for both modes; FMUL with rd=0x00, rr=0x5A -> z=1.
REQ-033 SHALL cover contention: both requesters valid continuously, i_rsp_ready=1 -> with FMUL_ARB_RR_EN, ids 0,1,0,1; without it, ids 0,0,0,0.
REQ-034 SHALL cover backpressure: i_rsp_ready=0 for 5 cycles in RESP -> outputs stable, o_req_ready=0 throughout, response completes on the first ready cycle.
REQ-035 SHALL cover reset in CALC: drop i_rst_n for 1 cycle -> no o_rsp_valid; all outputs 0; the next accept grants requester 0.
